i2c_cmd_sequencer: RTL
======================

Name: i2c_cmd_sequencer

Overview:
- Upstream command source for the I2C master engine; one clock domain with the master's command side.
- Holds a host-loaded table of register transactions and issues them in order over a valid/ready command handshake.
- Collects read-back bytes from the master's response stream into a byte buffer, exposed through an index-select port (button/LED style).
- Reports completion, NACK failures and timeouts.

Parameters:
- NUM_CMDS, 8, command table depth (entries 0..NUM_CMDS-1)
- DEV_ADDR, 7'h6B, 7-bit slave address driven on every command
- RBUF_BYTES, 8, read-back buffer depth in bytes
- GAP_CYC, 16, idle cycles inserted between commands (bus free time)
- TIMEOUT_CYC, 4095, maximum cycles waiting on ready or response before error

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tbl_we  in  1  table write strobe (ignored while busy)
- tbl_addr  in  $clog2(NUM_CMDS)  table write index
- tbl_data  in  20  {rw[19], rlen_m1[18:16], reg[15:8], wdata[7:0]}
- n_cmds  in  $clog2(NUM_CMDS)+1  number of entries to run, sampled on start
- start  in  1  single-cycle run request
- cmd_valid  out  1  command offered to master
- cmd_ready  in  1  master accepts command
- cmd_rw  out  1  0=write, 1=read
- cmd_dev  out  7  slave address (= DEV_ADDR)
- cmd_reg  out  8  register address
- cmd_wdata  out  8  write data
- cmd_rlen  out  4  read byte count (rlen_m1+1)
- rsp_valid  in  1  master response beat
- rsp_data  in  8  read byte, meaningful on read beats
- rsp_last  in  1  final beat of the transaction
- rsp_nack  in  1  slave NACKed; qualified by rsp_valid and always with rsp_last
- rd_sel  in  $clog2(RBUF_BYTES)  read-back buffer index
- rd_byte  out  8  buffer[rd_sel], registered
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at successful end
- error  out  1  sticky; cleared by the next accepted start
- err_idx  out  $clog2(NUM_CMDS)  entry that failed
- ovf  out  1  sticky; read byte dropped because buffer full
- rbuf_count  out  $clog2(RBUF_BYTES)+1  bytes stored this run

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs are 0: cmd_valid, busy, done, error, err_idx, ovf, rbuf_count, rd_byte and cmd_* fields. Table and buffer contents are not reset.
- Table write: tbl_we in IDLE/DONE/ERROR writes tbl_data at tbl_addr the same edge. Out-of-range addresses are ignored.
- start:
  - Accepted only when not busy; start while busy is ignored.
  - On accept: clear error, ovf and rbuf_count; reset idx to 0; latch n_cmds.
  - If the latched count is 0: go to DONE and pulse done the next cycle.
- States:
  - IDLE: wait for start.
  - ISSUE:
    - Drive cmd_* from table[idx] with cmd_valid=1.
    - cmd_* stay stable until cmd_valid&cmd_ready, then go to WAIT_RSP.
  - WAIT_RSP:
    - On a read beat (cmd_rw=1, rsp_valid, !rsp_nack), store rsp_data at buffer[rbuf_count] and increment; if rbuf_count==RBUF_BYTES, drop the byte and set ovf.
    - On rsp_valid&rsp_last: if nack, go to ERROR; otherwise go to GAP.
  - GAP:
    - Count GAP_CYC cycles.
    - Then idx++; if idx==latched count, go to DONE, else go to ISSUE.
  - DONE: pulse done one cycle, then IDLE.
  - ERROR: error=1 and err_idx=idx, then IDLE.
- busy=1 in ISSUE, WAIT_RSP and GAP.
- Timeout: a counter runs in ISSUE and WAIT_RSP and restarts on each state entry. Reaching TIMEOUT_CYC goes to ERROR; cmd_valid drops the next cycle.
- Response beats outside WAIT_RSP are ignored.
- rd_byte: 1-cycle latency from rd_sel. Out-of-range rd_sel returns 8'h00. Valid in all states; a same-cycle buffer write is reflected the following cycle.
- rst_n low mid-transaction aborts immediately. cmd_valid is 0 after that edge, with no done or error pulse.

Optional Feature:
- Macro I2C_SEQ_RETRY_EN.
- Defined:
  - A NACK in WAIT_RSP re-enters ISSUE for the same idx after GAP_CYC idle cycles, up to 3 retries per entry.
  - rbuf_count rewinds to its value at the entry's issue, so a retry does not duplicate bytes.
  - The 4th NACK goes to ERROR.
  - Timeouts are never retried.
- Undefined: the first NACK goes to ERROR; no retry counter is synthesized.

Test Plan:
- Load entry0={0,0,8'h10,8'hAC}, n_cmds=1, start; ready after 2 cycles; beat last=1 -> cmd_reg=10, cmd_wdata=AC held stable until accept; done pulses GAP_CYC+1 cycles after the response; error=0.
- Entry0 read rlen_m1=2, reg 6B; beats 11,22,33 (last on 33) -> rbuf_count=3; rd_sel=2 gives rd_byte=33 one cycle later; ovf=0.
- RBUF_BYTES=8, two reads of 6 bytes -> rbuf_count=8, ovf=1, done still pulses; buffer[7] = 2nd entry's 2nd byte.
- 3 entries, NACK on entry1 -> error=1, err_idx=1, entry2 never issued. With I2C_SEQ_RETRY_EN and a NACK then ACK: 2 issues of entry1, done=1.
- cmd_ready held 0 -> error at TIMEOUT_CYC, cmd_valid=0. Start while busy: no effect. n_cmds=0: done the cycle after start.
- rst_n=0 during WAIT_RSP -> next cycle busy=0, cmd_valid=0, no done; a later start runs cleanly from entry 0.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// Command sequencer feeding an I2C master: runs a host-loaded register transaction table
// and gathers read-back bytes. Define I2C_SEQ_RETRY_EN to retry NACKed entries up to 3 times.
module i2c_cmd_sequencer #(
  parameter int         NUM_CMDS    = 8,
  parameter logic [6:0] DEV_ADDR    = 7'h6B,
  parameter int         RBUF_BYTES  = 8,
  parameter int         GAP_CYC     = 16,
  parameter int         TIMEOUT_CYC = 4095
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tbl_we,
  input  logic [$clog2(NUM_CMDS)-1:0]     tbl_addr,
  input  logic [19:0]                     tbl_data,
  input  logic [$clog2(NUM_CMDS):0]       n_cmds,
  input  logic                            start,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic                            cmd_rw,
  output logic [6:0]                      cmd_dev,
  output logic [7:0]                      cmd_reg,
  output logic [7:0]                      cmd_wdata,
  output logic [3:0]                      cmd_rlen,
  input  logic                            rsp_valid,
  input  logic [7:0]                      rsp_data,
  input  logic                            rsp_last,
  input  logic                            rsp_nack,
  input  logic [$clog2(RBUF_BYTES)-1:0]   rd_sel,
  output logic [7:0]                      rd_byte,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [$clog2(NUM_CMDS)-1:0]     err_idx,
  output logic                            ovf,
  output logic [$clog2(RBUF_BYTES):0]     rbuf_count
);

  localparam int IW  = $clog2(NUM_CMDS);
  localparam int CW  = IW + 1;
  localparam int RW  = $clog2(RBUF_BYTES);
  localparam int RCW = RW + 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int GW  = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERR} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [RCW-1:0]  rbuf_count_q, rbuf_count_d;
  logic            error_q, error_d;
  logic [IW-1:0]   err_idx_q, err_idx_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      rd_byte_q, rd_byte_d;

  logic [19:0]     tbl_mem [NUM_CMDS];
  logic [7:0]      rbuf_mem [RBUF_BYTES];

  logic [19:0]     cur;
  logic [CW-1:0]   n_lat;
  logic            buf_we;
  logic [RW-1:0]   buf_waddr;
  logic            to_err;
  logic            redo_now;

`ifdef I2C_SEQ_RETRY_EN
  logic [1:0]      retry_q, retry_d;
  logic            redo_q, redo_d;
  logic [RCW-1:0]  mark_q, mark_d;
  assign redo_now = redo_q;
`else
  assign redo_now = 1'b0;
`endif

  assign cur   = tbl_mem[idx_q[IW-1:0]];
  // Requests beyond the table depth are clamped so idx never leaves the table.
  assign n_lat = (int'(n_cmds) > NUM_CMDS) ? CW'(NUM_CMDS) : n_cmds;

  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_GAP);
  assign done       = (state_q == S_DONE);
  assign cmd_valid  = (state_q == S_ISSUE);
  assign cmd_rw     = cmd_valid & cur[19];
  assign cmd_dev    = cmd_valid ? DEV_ADDR : 7'h00;
  assign cmd_reg    = cmd_valid ? cur[15:8] : 8'h00;
  assign cmd_wdata  = cmd_valid ? cur[7:0] : 8'h00;
  assign cmd_rlen   = cmd_valid ? ({1'b0, cur[18:16]} + 4'd1) : 4'd0;
  assign error      = error_q;
  assign err_idx    = err_idx_q;
  assign ovf        = ovf_q;
  assign rbuf_count = rbuf_count_q;
  assign rd_byte    = rd_byte_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q + TW'(1);
    gap_d        = gap_q + GW'(1);
    rbuf_count_d = rbuf_count_q;
    error_d      = error_q;
    err_idx_d    = err_idx_q;
    ovf_d        = ovf_q;
    buf_we       = 1'b0;
    buf_waddr    = rbuf_count_q[RW-1:0];
    to_err       = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
    retry_d      = retry_q;
    redo_d       = redo_q;
    mark_d       = mark_q;
`endif
    case (state_q)
      S_ISSUE: begin
        if (cmd_ready) begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          to_err = 1'b1;
        end
      end
      S_WAIT: begin
        if (rsp_valid && cur[19] && !rsp_nack) begin
          if (rbuf_count_q < RCW'(RBUF_BYTES)) begin
            buf_we       = 1'b1;
            rbuf_count_d = rbuf_count_q + RCW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (rsp_valid && rsp_last) begin
          if (rsp_nack) begin
`ifdef I2C_SEQ_RETRY_EN
            // Rewind so a retried read refills the same buffer slots.
            if (retry_q != 2'd3) begin
              retry_d      = retry_q + 2'd1;
              redo_d       = 1'b1;
              rbuf_count_d = mark_q;
              state_d      = S_GAP;
              gap_d        = '0;
            end else begin
              to_err = 1'b1;
            end
`else
            to_err = 1'b1;
`endif
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          to_err = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          if (redo_now) begin
            state_d = S_ISSUE;
            tmo_d   = '0;
`ifdef I2C_SEQ_RETRY_EN
            redo_d  = 1'b0;
`endif
          end else if ((idx_q + CW'(1)) == cnt_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + CW'(1);
            state_d = S_ISSUE;
            tmo_d   = '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_d = '0;
            mark_d  = rbuf_count_q;
`endif
          end
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default: ;
    endcase

    if (to_err) begin
      state_d   = S_ERR;
      error_d   = 1'b1;
      err_idx_d = idx_q[IW-1:0];
    end

    if (start && !busy) begin
      error_d      = 1'b0;
      ovf_d        = 1'b0;
      rbuf_count_d = '0;
      idx_d        = '0;
      cnt_d        = n_lat;
      tmo_d        = '0;
      state_d      = (n_lat == '0) ? S_DONE : S_ISSUE;
`ifdef I2C_SEQ_RETRY_EN
      retry_d      = '0;
      redo_d       = 1'b0;
      mark_d       = '0;
`endif
    end
  end

  // A byte landing on the selected slot this cycle is forwarded directly.
  always_comb begin
    rd_byte_d = 8'h00;
    if (int'(rd_sel) < RBUF_BYTES) begin
      rd_byte_d = rbuf_mem[rd_sel];
      if (buf_we && (buf_waddr == rd_sel)) rd_byte_d = rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      gap_q        <= '0;
      rbuf_count_q <= '0;
      error_q      <= 1'b0;
      err_idx_q    <= '0;
      ovf_q        <= 1'b0;
      rd_byte_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      rbuf_count_q <= rbuf_count_d;
      error_q      <= error_d;
      err_idx_q    <= err_idx_d;
      ovf_q        <= ovf_d;
      rd_byte_q    <= rd_byte_d;
    end
  end

`ifdef I2C_SEQ_RETRY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retry_q <= '0;
      redo_q  <= 1'b0;
      mark_q  <= '0;
    end else begin
      retry_q <= retry_d;
      redo_q  <= redo_d;
      mark_q  <= mark_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (tbl_we && !busy && (int'(tbl_addr) < NUM_CMDS)) tbl_mem[tbl_addr] <= tbl_data;
    if (buf_we && rst_n) rbuf_mem[buf_waddr] <= rsp_data;
  end

endmodule
